// File: rtl/byte_unstriping.sv
// Re-serializes 4-lane byte groups into a single byte stream, lane 0 first.
// Two-entry group buffer; groups that arrive while it is full are dropped and flagged.
module byte_unstriping #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             byteUnstripingCLK,
  input  logic             byteUnstripingRST,
  input  logic [WIDTH-1:0] stripedLane0,
  input  logic [WIDTH-1:0] stripedLane1,
  input  logic [WIDTH-1:0] stripedLane2,
  input  logic [WIDTH-1:0] stripedLane3,
  input  logic             stripedVLD,
  output logic             unstripingRDY,
  output logic [WIDTH-1:0] byteUnstripingOUT,
  output logic             byteUnstripingVLD,
  output logic             unstripingOVF
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1][0:3];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic [1:0]       sel;
  logic             pop_now;
  logic             push;

  // The last lane of the head group frees its entry at the same edge, so a
  // full buffer can still accept a strobe in that cycle.
  assign pop_now       = (occ != 2'd0) && (sel == 2'd3);
  assign unstripingRDY = (occ < FULL) || pop_now;
  assign push          = stripedVLD && unstripingRDY;

  // Group storage carries no reset; pointers and occupancy qualify it.
  always_ff @(posedge byteUnstripingCLK) begin
    if (push && !byteUnstripingRST) begin
      mem[wr_ptr][0] <= stripedLane0;
      mem[wr_ptr][1] <= stripedLane1;
      mem[wr_ptr][2] <= stripedLane2;
      mem[wr_ptr][3] <= stripedLane3;
    end
  end

  always_ff @(posedge byteUnstripingCLK) begin
    if (byteUnstripingRST) begin
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      occ               <= 2'd0;
      sel               <= 2'd0;
      byteUnstripingOUT <= '0;
      byteUnstripingVLD <= 1'b0;
      unstripingOVF     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (stripedVLD && !unstripingRDY) begin
        unstripingOVF <= 1'b1;
      end

      case ({push, pop_now})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      // Serializer reads only entries present before this edge: no bypass.
      if (occ != 2'd0) begin
        byteUnstripingOUT <= mem[rd_ptr][sel];
        byteUnstripingVLD <= 1'b1;
        sel               <= sel + 2'd1;
        if (pop_now) begin
          rd_ptr <= ~rd_ptr;
        end
      end else begin
        byteUnstripingVLD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: directed scenarios plus random strobes,
// compared cycle by cycle against a queue-based reference model.
module tb_byte_unstriping;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lane0, lane1, lane2, lane3;
  logic       svld;
  logic       rdy;
  logic [7:0] bout;
  logic       bvld;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: groups waiting or in progress, and bytes already sent from the head.
  logic [31:0] m_q[$];
  int          m_cnt = 0;
  logic [7:0]  m_out = 8'h00;
  logic        m_vld = 1'b0;
  logic        m_ovf = 1'b0;
  bit          inited = 1'b0;

  byte_unstriping #(.WIDTH(8), .DEPTH(2)) dut (
    .byteUnstripingCLK (clk),
    .byteUnstripingRST (rst),
    .stripedLane0      (lane0),
    .stripedLane1      (lane1),
    .stripedLane2      (lane2),
    .stripedLane3      (lane3),
    .stripedVLD        (svld),
    .unstripingRDY     (rdy),
    .byteUnstripingOUT (bout),
    .byteUnstripingVLD (bvld),
    .unstripingOVF     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_rdy();
    return (m_q.size() < 2) || (m_q.size() > 0 && m_cnt == 3);
  endfunction

  // One clock: drive inputs, check RDY mid-cycle, advance model at the edge, check outputs after it.
  task automatic cycle(input bit v, input logic [31:0] g, input bit r);
    bit exp_rdy;
    rst   = r;
    svld  = v;
    lane0 = g[7:0];
    lane1 = g[15:8];
    lane2 = g[23:16];
    lane3 = g[31:24];
    #1;
    exp_rdy = model_rdy();
    if (inited) check("rdy", {31'd0, rdy}, {31'd0, exp_rdy});
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_cnt = 0;
      m_out = 8'h00;
      m_vld = 1'b0;
      m_ovf = 1'b0;
      inited = 1'b1;
    end else begin
      if (v && !exp_rdy) m_ovf = 1'b1;
      if (m_q.size() > 0) begin
        m_out = 8'((m_q[0] >> (8 * m_cnt)) & 32'hff);
        m_vld = 1'b1;
        m_cnt++;
        if (m_cnt == 4) begin
          void'(m_q.pop_front());
          m_cnt = 0;
        end
      end else begin
        m_vld = 1'b0;
      end
      if (v && exp_rdy) m_q.push_back(g);
    end
    #1;
    if (inited) begin
      check("vld", {31'd0, bvld}, {31'd0, m_vld});
      check("out", {24'd0, bout}, {24'd0, m_out});
      check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; svld = 1'b0;
    lane0 = '0; lane1 = '0; lane2 = '0; lane3 = '0;
    do_reset();
    do_reset();
    check("reset_out", {24'd0, bout}, 32'h0);
    check("reset_rdy", {31'd0, rdy}, 32'h1);

    // single group
    cycle(1'b1, 32'h44332211, 1'b0);
    check("single_lane0", {24'd0, bout}, 32'h0);
    cycle(1'b0, 32'h0, 1'b0);
    check("single_first", {24'd0, bout}, 32'h11);
    idle(6);
    check("single_hold", {24'd0, bout}, 32'h44);
    check("single_idle_vld", {31'd0, bvld}, 32'h0);

    // back-to-back every 4 cycles
    cycle(1'b1, 32'h11111111, 1'b0);
    idle(3);
    cycle(1'b1, 32'h88888888, 1'b0);
    idle(4);
    check("b2b_last", {24'd0, bout}, 32'h88);
    idle(2);
    check("b2b_ovf", {31'd0, ovf}, 32'h0);

    // strobe every cycle: G2, G3 dropped
    cycle(1'b1, 32'hA3A2A1A0, 1'b0);
    cycle(1'b1, 32'hB3B2B1B0, 1'b0);
    cycle(1'b1, 32'hC3C2C1C0, 1'b0);
    check("every_ovf", {31'd0, ovf}, 32'h1);
    cycle(1'b1, 32'hD3D2D1D0, 1'b0);
    idle(10);
    check("every_hold", {24'd0, bout}, 32'hB3);
    do_reset();

    // simultaneous push/pop at full
    cycle(1'b1, 32'h03020100, 1'b0);
    cycle(1'b1, 32'h13121110, 1'b0);
    idle(2);
    check("full_rdy_pop", {31'd0, rdy}, 32'h1);
    cycle(1'b1, 32'h23222120, 1'b0);
    idle(12);
    check("full_ovf", {31'd0, ovf}, 32'h0);
    check("full_hold", {24'd0, bout}, 32'h23);

    // reset mid-group
    cycle(1'b1, 32'h77665544, 1'b0);
    idle(2);
    check("mid_lane1", {24'd0, bout}, 32'h55);
    cycle(1'b1, 32'h99999999, 1'b1);
    check("mid_rst_vld", {31'd0, bvld}, 32'h0);
    idle(2);
    cycle(1'b1, 32'hDDCCBBAA, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    check("mid_fresh", {24'd0, bout}, 32'hAA);
    idle(5);

    // overflow stickiness
    cycle(1'b1, 32'h01010101, 1'b0);
    cycle(1'b1, 32'h02020202, 1'b0);
    cycle(1'b1, 32'h03030303, 1'b0);
    idle(20);
    cycle(1'b1, 32'h5A4B3C2D, 1'b0);
    idle(3);
    cycle(1'b1, 32'hF0E0D0C0, 1'b0);
    idle(8);
    check("sticky_ovf", {31'd0, ovf}, 32'h1);
    do_reset();
    check("sticky_clear", {31'd0, ovf}, 32'h0);

    // random strobes with occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 99) == 0));
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
